// File: rtl/f3_move_scheduler.sv
// f3_move_scheduler
// Sequences the 4-bit instruction / scramble pair into the f3 GPU. User key
// commands and an LFSR auto-scramble generator share one command path.
// GPU rules kept by this block:
//   - scramble settles one cycle before a command and stays stable during it;
//   - a rotate instruction lasts exactly one cycle, because the GPU writes RAM
//     on every cycle the instruction is non-zero;
//   - instruction returns to 0 between commands so the GPU re-arms.
// Handshake: a key command is taken on a cycle where key_valid && key_ready.
// key_ready is high only in IDLE. key_valid seen outside IDLE is neither
// queued nor taken later.
// Build option: define AUTO_SCRAMBLE_EN to include the LFSR auto-scramble
// path. Without it, auto_start is ignored and auto_busy/step_count read 0.
// dbg_state exposes the FSM state (0=IDLE 1=SETUP 2=ISSUE 3=RELEASE).
module f3_move_scheduler #(
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned SCRAMBLE_MOVES = 64,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [2:0]  key_cmd,
  input  logic        key_rotate,
  output logic        key_ready,
  input  logic        auto_start,
  output logic        auto_busy,
  output logic [3:0]  instruction,
  output logic        scramble,
  output logic [15:0] step_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_ISSUE   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // Timers load "count - 1" and leave their state when they reach 0.
  localparam logic [15:0] HOLD_M1 = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_M1  = 16'(GAP_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cmd_q;
  logic        rot_q;
  logic [15:0] timer_q;
  logic [3:0]  instr_q;
  logic        scr_q;

  // Auto-path interface seen by the FSM.
  logic        auto_req;     // auto_start as seen by this build
  logic        more_steps;   // current auto run still owes steps
  logic [3:0]  auto_cmd;     // next auto command drawn from the LFSR
  logic        auto_rot;     // next auto rotate flag
  logic        start_run;    // IDLE accepts an auto run this cycle
  logic        gap_done;     // last RELEASE cycle
  logic        next_run;     // RELEASE chains straight into another auto step
  logic        end_run;      // RELEASE returns to IDLE
  logic        cmd_ok;       // key_cmd is one of the four directions

  assign cmd_ok    = (key_cmd >= 3'd1) && (key_cmd <= 3'd4);
  assign start_run = (state_q == S_IDLE) && auto_req;
  assign gap_done  = (state_q == S_RELEASE) && (timer_q == 16'd0);
  assign next_run  = gap_done && more_steps;
  assign end_run   = gap_done && !more_steps;

`ifdef AUTO_SCRAMBLE_EN
  localparam logic [15:0] MOVES = 16'(SCRAMBLE_MOVES);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_next;
  logic        busy_q;
  logic [15:0] steps_q;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form.
  assign lfsr_next  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign auto_cmd   = {2'b00, lfsr_q[1:0]} + 4'd1;
  assign auto_rot   = lfsr_q[2];
  assign auto_req   = auto_start;
  assign more_steps = busy_q && (steps_q < MOVES);

  // Auto-run bookkeeping: LFSR advances once per drawn command, the step
  // counter counts on the first ISSUE cycle and saturates at MOVES.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      lfsr_q  <= LFSR_SEED;
      busy_q  <= 1'b0;
      steps_q <= 16'd0;
    end else begin
      if (start_run || next_run) begin
        lfsr_q <= lfsr_next;
      end
      if (start_run) begin
        busy_q  <= 1'b1;
        steps_q <= 16'd0;
      end else if (end_run) begin
        busy_q  <= 1'b0;
      end
      if ((state_q == S_SETUP) && busy_q && (steps_q < MOVES)) begin
        steps_q <= steps_q + 16'd1;
      end
    end
  end

  assign auto_busy  = busy_q;
  assign step_count = steps_q;
`else
  logic        unused_auto;
  logic [15:0] unused_cfg;

  assign unused_auto = auto_start;
  assign unused_cfg  = 16'(SCRAMBLE_MOVES) ^ LFSR_SEED;
  assign auto_req    = 1'b0;
  assign more_steps  = 1'b0;
  assign auto_cmd    = 4'd0;
  assign auto_rot    = 1'b0;
  assign auto_busy   = 1'b0;
  assign step_count  = 16'd0;
`endif

  // Command FSM with registered instruction/scramble. Outputs are updated on
  // the edge that enters each state, so scramble is already valid during
  // SETUP and the instruction is valid for every ISSUE cycle.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cmd_q   <= 4'd0;
      rot_q   <= 1'b0;
      timer_q <= 16'd0;
      instr_q <= 4'd0;
      scr_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          instr_q <= 4'd0;
          if (start_run) begin
            cmd_q   <= auto_cmd;
            rot_q   <= auto_rot;
            scr_q   <= auto_rot;
            state_q <= S_SETUP;
          end else if (key_valid && cmd_ok) begin
            cmd_q   <= {1'b0, key_cmd};
            rot_q   <= key_rotate;
            scr_q   <= key_rotate;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          instr_q <= cmd_q;
          timer_q <= rot_q ? 16'd0 : HOLD_M1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (timer_q == 16'd0) begin
            instr_q <= 4'd0;
            timer_q <= GAP_M1;
            state_q <= S_RELEASE;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        S_RELEASE: begin
          if (timer_q != 16'd0) begin
            timer_q <= timer_q - 16'd1;
          end else if (next_run) begin
            cmd_q   <= auto_cmd;
            rot_q   <= auto_rot;
            scr_q   <= auto_rot;
            state_q <= S_SETUP;
          end else begin
            scr_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign key_ready   = (state_q == S_IDLE);
  assign instruction = instr_q;
  assign scramble    = scr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_f3_move_scheduler.sv
// tb_f3_move_scheduler
// Directed bench for f3_move_scheduler (HOLD=4, GAP=2, SCRAMBLE_MOVES=3).
// A negedge monitor folds every non-zero instruction run into
// {rotate, cmd, length} and pops the expected run pushed when the stimulus
// was driven. The auto-scramble steps run only when AUTO_SCRAMBLE_EN is
// defined; otherwise auto_start must be ignored.
module tb_f3_move_scheduler;

  localparam int HOLD  = 4;
  localparam int GAP   = 2;
  localparam int MOVES = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [2:0]  key_cmd;
  logic        key_rotate;
  logic        key_ready;
  logic        auto_start;
  logic        auto_busy;
  logic [3:0]  instruction;
  logic        scramble;
  logic [15:0] step_count;
  logic [1:0]  dbg_state;

  f3_move_scheduler #(
    .HOLD_CYCLES    (HOLD),
    .GAP_CYCLES     (GAP),
    .SCRAMBLE_MOVES (MOVES),
    .LFSR_SEED      (SEED)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_cmd     (key_cmd),
    .key_rotate  (key_rotate),
    .key_ready   (key_ready),
    .auto_start  (auto_start),
    .auto_busy   (auto_busy),
    .instruction (instruction),
    .scramble    (scramble),
    .step_count  (step_count),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 sysclk = ~sysclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_lfsr = SEED;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic rot, input logic [3:0] cmd, input logic [7:0] len);
    return {3'b000, rot, cmd, len};
  endfunction

  // Inputs change 1 time unit after the active edge; outputs are read there too.
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic push_key(input logic rot, input logic [3:0] cmd);
    exp_q.push_back(enc(rot, cmd, rot ? 8'd1 : 8'(HOLD)));
  endtask

  // Reference LFSR: taps 16,14,13,11 -> feedback from bits 0,2,3,5.
  task automatic push_auto_run();
    logic [3:0] c;
    logic       r;
    for (int i = 0; i < MOVES; i++) begin
      c = 4'(model_lfsr[1:0]) + 4'd1;
      r = model_lfsr[2];
      push_key(r, c);
      model_lfsr = {^(model_lfsr & 16'h002D), model_lfsr[15:1]};
    end
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (!key_ready && i < budget) begin
      tick();
      i++;
    end
    check("wait_idle_timeout", 32'(key_ready), 32'd1);
  endtask

  task automatic wait_busy_low(input int budget);
    int i = 0;
    while (auto_busy && i < budget) begin
      tick();
      i++;
    end
    check("auto_run_timeout", 32'(auto_busy), 32'd0);
  endtask

  // Scoreboard: compare each completed instruction run with the queue head.
  logic [7:0] run_len = 8'd0;
  logic [3:0] run_cmd = 4'd0;
  logic       run_rot = 1'b0;
  logic [15:0] got;
  always @(negedge sysclk) begin
    if (reset === 1'b1) begin
      run_len <= 8'd0;
    end else if (instruction !== 4'd0) begin
      if (run_len == 8'd0) begin
        run_cmd <= instruction;
        run_rot <= scramble;
      end
      run_len <= run_len + 8'd1;
    end else if (run_len != 8'd0) begin
      got = enc(run_rot, run_cmd, run_len);
      if (exp_q.size() == 0) begin
        check("run_unexpected", 32'(got), 32'd0);
      end else begin
        check("run_cmd_rot_len", 32'(got), 32'(exp_q.pop_front()));
      end
      run_len <= 8'd0;
    end
  end

  initial begin
    reset      = 1'b1;
    key_valid  = 1'b0;
    key_cmd    = 3'd0;
    key_rotate = 1'b0;
    auto_start = 1'b0;

    // 1. reset state
    repeat (3) tick();
    check("rst_instruction", 32'(instruction), 32'd0);
    check("rst_scramble",    32'(scramble),    32'd0);
    check("rst_key_ready",   32'(key_ready),   32'd1);
    check("rst_auto_busy",   32'(auto_busy),   32'd0);
    check("rst_step_count",  32'(step_count),  32'd0);
    check("rst_state",       32'(dbg_state),   32'd0);
    reset = 1'b0;
    tick();

    // 2. cursor move right, cycle-exact
    key_valid = 1'b1; key_cmd = 3'd2; key_rotate = 1'b0;
    check("mv_ready_k", 32'(key_ready), 32'd1);
    push_key(1'b0, 4'd2);
    tick();
    key_valid = 1'b0;
    check("mv_scr_k1",   32'(scramble),    32'd0);
    check("mv_instr_k1", 32'(instruction), 32'd0);
    check("mv_ready_k1", 32'(key_ready),   32'd0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("mv_instr_issue", 32'(instruction), 32'd2);
    end
    tick();
    check("mv_instr_k6", 32'(instruction), 32'd0);
    tick();
    check("mv_instr_k7", 32'(instruction), 32'd0);
    check("mv_ready_k7", 32'(key_ready),   32'd0);
    tick();
    check("mv_ready_k8", 32'(key_ready),   32'd1);

    // 3. rotate down: one-cycle instruction; key_valid held while busy
    key_valid = 1'b1; key_cmd = 3'd4; key_rotate = 1'b1;
    push_key(1'b1, 4'd4);
    tick();
    key_cmd = 3'd1; key_rotate = 1'b0;
    check("rot_scr_k1",   32'(scramble),    32'd1);
    check("rot_instr_k1", 32'(instruction), 32'd0);
    tick();
    check("rot_instr_k2", 32'(instruction), 32'd4);
    check("rot_scr_k2",   32'(scramble),    32'd1);
    tick();
    check("rot_instr_k3", 32'(instruction), 32'd0);
    check("rot_scr_k3",   32'(scramble),    32'd1);
    tick();
    check("rot_ready_k4", 32'(key_ready),   32'd0);
    tick();
    key_valid = 1'b0;
    check("rot_ready_k5", 32'(key_ready),   32'd1);
    check("rot_scr_k5",   32'(scramble),    32'd0);

    // 4. invalid commands are taken and dropped
    key_valid = 1'b1; key_cmd = 3'd0; key_rotate = 1'b0;
    tick();
    key_cmd = 3'd7; key_rotate = 1'b1;
    check("bad0_ready", 32'(key_ready), 32'd1);
    tick();
    key_valid = 1'b0;
    check("bad7_ready", 32'(key_ready), 32'd1);
    repeat (3) begin
      tick();
      check("bad_instr", 32'(instruction), 32'd0);
    end

`ifdef AUTO_SCRAMBLE_EN
    // 5. auto-scramble run; keys and a second auto_start are ignored
    auto_start = 1'b1;
    push_auto_run();
    tick();
    auto_start = 1'b0;
    key_valid = 1'b1; key_cmd = 3'd3; key_rotate = 1'b0;
    check("auto_busy_start", 32'(auto_busy),  32'd1);
    check("auto_cnt_start",  32'(step_count), 32'd0);
    check("auto_ready_low",  32'(key_ready),  32'd0);
    tick();
    tick();
    auto_start = 1'b1;
    tick();
    auto_start = 1'b0;
    wait_busy_low(200);
    key_valid = 1'b0;
    check("auto_end_ready", 32'(key_ready),   32'd1);
    check("auto_end_count", 32'(step_count),  32'd3);
    check("auto_end_scr",   32'(scramble),    32'd0);
    check("auto_end_instr", 32'(instruction), 32'd0);
    repeat (3) tick();
    check("auto_cnt_hold",  32'(step_count),  32'd3);
`else
    // 5. auto_start has no effect in this build
    auto_start = 1'b1;
    tick();
    auto_start = 1'b0;
    check("noauto_busy",  32'(auto_busy),  32'd0);
    check("noauto_count", 32'(step_count), 32'd0);
    check("noauto_ready", 32'(key_ready),  32'd1);
    repeat (4) begin
      tick();
      check("noauto_instr", 32'(instruction), 32'd0);
    end
`endif

    // 6. reset during ISSUE of a cursor move
    key_valid = 1'b1; key_cmd = 3'd1; key_rotate = 1'b0;
    tick();
    key_valid = 1'b0;
    tick();
    check("rstmid_issue", 32'(instruction), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_instr", 32'(instruction), 32'd0);
    check("rstmid_scr",   32'(scramble),    32'd0);
    check("rstmid_ready", 32'(key_ready),   32'd1);
    check("rstmid_count", 32'(step_count),  32'd0);
    model_lfsr = SEED;

    // key and auto_start in the same IDLE cycle
    key_valid = 1'b1; key_cmd = 3'd3; key_rotate = 1'b1;
    auto_start = 1'b1;
`ifdef AUTO_SCRAMBLE_EN
    push_auto_run();
    tick();
    key_valid = 1'b0;
    auto_start = 1'b0;
    check("prio_busy", 32'(auto_busy), 32'd1);
    wait_busy_low(200);
    check("prio_count", 32'(step_count), 32'd3);
`else
    push_key(1'b1, 4'd3);
    tick();
    key_valid = 1'b0;
    auto_start = 1'b0;
    check("prio_scr", 32'(scramble), 32'd1);
`endif
    wait_idle(50);
    repeat (2) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
